bringup_sequencer: RTL and testbench

BRINGUP_SEQUENCER -- requirements
Module: bringup_sequencer

---
 rtl/bringup_pkg.sv | 19 +
 rtl/heartbeat_div.sv | 33 +++
 rtl/bringup_sequencer.sv | 156 +++++++++++++++
 tb/tb_bringup_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bringup_pkg.sv
// Shared state encoding and default parameters for the power-on bring-up sequencer.
// Purely declarative; no logic, no latency, no flow control.
package bringup_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int          DEF_NUM_PHASES = 4;
  localparam int          DEF_CNT_W      = 16;
  localparam logic [31:0] DEF_RUN_CYCLES = 32'd10000;
  localparam int          DEF_BLINK_LOG2 = 8;

  // cur_phase is 3 bits wide, so the length table is always sized for 8 phases.
  localparam int          MAX_PHASES     = 8;

endpackage

// File: rtl/heartbeat_div.sv
// Free-running divider: heartbeat toggles once every 2^BLINK_LOG2 clocks, first toggle 2^BLINK_LOG2 edges after reset.
// Ignores the sequencer entirely; no inputs other than clock and reset, no backpressure.
module heartbeat_div
  import bringup_pkg::*;
#(
  parameter int BLINK_LOG2 = DEF_BLINK_LOG2
) (
  input  logic osc_clk,
  input  logic reset,
  output logic heartbeat
);

  logic [BLINK_LOG2-1:0] cnt_q, cnt_d;
  logic                  hb_q, hb_d;

  always_comb begin
    cnt_d = cnt_q + BLINK_LOG2'(1);
    hb_d  = (&cnt_q) ? ~hb_q : hb_q;
  end

  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      hb_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hb_q  <= hb_d;
    end
  end

  assign heartbeat = hb_q;

endmodule

// File: rtl/bringup_sequencer.sv
// Steps through NUM_PHASES timed phases after start, with a RUN-cycle watchdog; outputs registered, one-cycle response.
// abort beats start, start is ignored while running; no backpressure on any input.
module bringup_sequencer
  import bringup_pkg::*;
#(
  parameter int          NUM_PHASES = DEF_NUM_PHASES,
  parameter int          CNT_W      = DEF_CNT_W,
  parameter logic [31:0] RUN_CYCLES = DEF_RUN_CYCLES,
  parameter int          BLINK_LOG2 = DEF_BLINK_LOG2
) (
  input  logic                        osc_clk,
  input  logic                        reset,
  input  logic [NUM_PHASES*CNT_W-1:0] phase_len,
  input  logic                        start,
  input  logic                        abort,
  output logic [NUM_PHASES-1:0]       phase_en,
  output logic [2:0]                  cur_phase,
  output logic                        busy,
  output logic                        done,
  output logic                        timeout,
  output logic                        heartbeat
);

  state_e                  state_q, state_d;
  logic [NUM_PHASES-1:0]   phase_en_q, phase_en_d;
  logic [2:0]              cur_phase_q, cur_phase_d;
  logic [CNT_W-1:0]        phase_cnt_q, phase_cnt_d;
  logic [31:0]             run_cnt_q, run_cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    timeout_q, timeout_d;

  logic [CNT_W-1:0]        len_arr [MAX_PHASES];
  logic [CNT_W-1:0]        cur_len;
  logic [CNT_W-1:0]        eff_len;
  logic [2:0]              next_phase;
  logic                    phase_last;
  logic                    final_phase;
  logic                    wd_expire;

  for (genvar g = 0; g < MAX_PHASES; g++) begin : g_len
    if (g < NUM_PHASES) begin : g_used
      assign len_arr[g] = phase_len[g*CNT_W +: CNT_W];
    end else begin : g_unused
      assign len_arr[g] = '0;
    end
  end

  // Length is re-read every cycle; >= lets a shortened phase end as soon as it is already overdue.
  assign cur_len     = len_arr[cur_phase_q];
  assign eff_len     = (cur_len == '0) ? CNT_W'(1) : cur_len;
  assign phase_last  = ({1'b0, phase_cnt_q} + (CNT_W+1)'(1)) >= {1'b0, eff_len};
  assign final_phase = (cur_phase_q == 3'(NUM_PHASES - 1));
  assign wd_expire   = (run_cnt_q >= (RUN_CYCLES - 32'd1));
  assign next_phase  = cur_phase_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    phase_en_d  = phase_en_q;
    cur_phase_d = cur_phase_q;
    phase_cnt_d = phase_cnt_q;
    run_cnt_d   = run_cnt_q;
    busy_d      = busy_q;
    done_d      = done_q;
    timeout_d   = timeout_q;

    if (abort) begin
      state_d     = ST_IDLE;
      phase_en_d  = '0;
      cur_phase_d = '0;
      phase_cnt_d = '0;
      run_cnt_d   = '0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      timeout_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d     = ST_RUN;
            phase_en_d  = NUM_PHASES'(1);
            cur_phase_d = '0;
            phase_cnt_d = '0;
            run_cnt_d   = '0;
            busy_d      = 1'b1;
            done_d      = 1'b0;
            timeout_d   = 1'b0;
          end
        end
        ST_RUN: begin
          run_cnt_d = run_cnt_q + 32'd1;
          if (phase_last && final_phase) begin
            // Completion takes priority over a simultaneous watchdog expiry.
            state_d   = ST_DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            timeout_d = 1'b0;
          end else if (wd_expire) begin
            state_d   = ST_DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            timeout_d = 1'b1;
          end else if (phase_last) begin
            cur_phase_d = next_phase;
            phase_cnt_d = '0;
            for (int i = 0; i < NUM_PHASES; i++) begin
              if (3'(i) == next_phase) phase_en_d[i] = 1'b1;
            end
          end else begin
            phase_cnt_d = phase_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      phase_en_q  <= '0;
      cur_phase_q <= '0;
      phase_cnt_q <= '0;
      run_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_en_q  <= phase_en_d;
      cur_phase_q <= cur_phase_d;
      phase_cnt_q <= phase_cnt_d;
      run_cnt_q   <= run_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign phase_en  = phase_en_q;
  assign cur_phase = cur_phase_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;

  heartbeat_div #(
    .BLINK_LOG2 (BLINK_LOG2)
  ) u_heartbeat_div (
    .osc_clk   (osc_clk),
    .reset     (reset),
    .heartbeat (heartbeat)
  );

endmodule

// File: tb/tb_bringup_sequencer.sv
// Directed bench: three sequencer instances sharing stimulus, differing only in watchdog limit;
// instance a also uses a fast heartbeat so its divider can be checked within a short window.
module tb_bringup_sequencer;

  logic        osc_clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [63:0] phase_len;

  logic [3:0] a_en, b_en, c_en;
  logic [2:0] a_cur, b_cur, c_cur;
  logic       a_busy, b_busy, c_busy;
  logic       a_done, b_done, c_done;
  logic       a_to, b_to, c_to;
  logic       a_hb, b_hb, c_hb;

  int checks = 0;
  int errors = 0;

  always #5 osc_clk = ~osc_clk;

  bringup_sequencer #(.NUM_PHASES(4), .CNT_W(16), .RUN_CYCLES(32'd10000), .BLINK_LOG2(2)) dut_a (
    .osc_clk(osc_clk), .reset(reset), .phase_len(phase_len), .start(start), .abort(abort),
    .phase_en(a_en), .cur_phase(a_cur), .busy(a_busy), .done(a_done), .timeout(a_to), .heartbeat(a_hb));

  bringup_sequencer #(.NUM_PHASES(4), .CNT_W(16), .RUN_CYCLES(32'd8), .BLINK_LOG2(8)) dut_b (
    .osc_clk(osc_clk), .reset(reset), .phase_len(phase_len), .start(start), .abort(abort),
    .phase_en(b_en), .cur_phase(b_cur), .busy(b_busy), .done(b_done), .timeout(b_to), .heartbeat(b_hb));

  bringup_sequencer #(.NUM_PHASES(4), .CNT_W(16), .RUN_CYCLES(32'd10), .BLINK_LOG2(8)) dut_c (
    .osc_clk(osc_clk), .reset(reset), .phase_len(phase_len), .start(start), .abort(abort),
    .phase_en(c_en), .cur_phase(c_cur), .busy(c_busy), .done(c_done), .timeout(c_to), .heartbeat(c_hb));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag,
                        input logic busy_o, input logic done_o, input logic to_o,
                        input logic [2:0] cur_o, input logic [3:0] en_o,
                        input logic eb, input logic ed, input logic et,
                        input logic [2:0] ec, input logic [3:0] ee);
    chk({tag, ".busy"},    32'(busy_o), 32'(eb));
    chk({tag, ".done"},    32'(done_o), 32'(ed));
    chk({tag, ".timeout"}, 32'(to_o),   32'(et));
    chk({tag, ".cur"},     32'(cur_o),  32'(ec));
    chk({tag, ".en"},      32'(en_o),   32'(ee));
  endtask

  task automatic tick();
    @(negedge osc_clk);
  endtask

  // Lengths {1,2,3,4} with phase0=4: phase 0 on cycles 1-4, 1 on 5-7, 2 on 8-9, 3 on 10.
  function automatic logic [2:0] cur_of(input int c);
    if (c <= 4)      return 3'd0;
    else if (c <= 7) return 3'd1;
    else if (c <= 9) return 3'd2;
    else             return 3'd3;
  endfunction

  function automatic logic [3:0] en_of(input logic [2:0] p);
    logic [4:0] one;
    one = 5'd1;
    return 4'((one << (p + 3'd1)) - 5'd1);
  endfunction

  localparam logic [63:0] LEN_DEF = {16'd1, 16'd2, 16'd3, 16'd4};

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    phase_len = LEN_DEF;

    #2;
    chk_st("rst.a", a_busy, a_done, a_to, a_cur, a_en, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    chk("rst.a.hb", 32'(a_hb), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk_st("idle.a", a_busy, a_done, a_to, a_cur, a_en, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);

    // Full run; b hits its 8-cycle watchdog, c's 10-cycle watchdog ties with completion.
    start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      logic [2:0] pa, pb;
      tick();
      start = 1'b0;
      pa = (c <= 10) ? cur_of(c) : 3'd3;
      pb = (c <= 9) ? cur_of(c) : 3'd2;
      chk_st($sformatf("run.a.c%0d", c), a_busy, a_done, a_to, a_cur, a_en,
             c <= 10, c == 11, 1'b0, pa, en_of(pa));
      chk_st($sformatf("run.b.c%0d", c), b_busy, b_done, b_to, b_cur, b_en,
             c <= 8, c >= 9, c >= 9, pb, en_of(pb));
      chk_st($sformatf("run.c.c%0d", c), c_busy, c_done, c_to, c_cur, c_en,
             c <= 10, c == 11, 1'b0, pa, en_of(pa));
    end

    // Abort with simultaneous start at cycle 6, then restart; a start mid-run must be ignored.
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      start = 1'b0;
    end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk_st("abort.a", a_busy, a_done, a_to, a_cur, a_en, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    chk_st("abort.b", b_busy, b_done, b_to, b_cur, b_en, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      start = (c == 2);
      if (c == 1)
        chk_st("rerun.a.c1", a_busy, a_done, a_to, a_cur, a_en, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0001);
      if (c == 5)
        chk_st("rerun.a.c5", a_busy, a_done, a_to, a_cur, a_en, 1'b1, 1'b0, 1'b0, 3'd1, 4'b0011);
      if (c == 11)
        chk_st("rerun.a.c11", a_busy, a_done, a_to, a_cur, a_en, 1'b0, 1'b1, 1'b0, 3'd3, 4'b1111);
    end

    // All lengths zero: one cycle per phase, done four cycles after RUN entry.
    phase_len = '0;
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start = 1'b0;
      if (c <= 4)
        chk_st($sformatf("zero.a.c%0d", c), a_busy, a_done, a_to, a_cur, a_en,
               1'b1, 1'b0, 1'b0, 3'(c - 1), en_of(3'(c - 1)));
      else
        chk_st("zero.a.c5", a_busy, a_done, a_to, a_cur, a_en, 1'b0, 1'b1, 1'b0, 3'd3, 4'b1111);
    end
    chk_st("zero.b.c5", b_busy, b_done, b_to, b_cur, b_en, 1'b0, 1'b1, 1'b0, 3'd3, 4'b1111);

    // Shrinking the active phase's length ends it on the next evaluated cycle.
    phase_len = {16'd1, 16'd2, 16'd3, 16'd10};
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("len.a.c2.cur", 32'(a_cur), 32'd0);
    phase_len = {16'd1, 16'd2, 16'd3, 16'd1};
    tick();
    chk("len.a.c3.cur", 32'(a_cur), 32'd1);
    chk("len.a.c3.en", 32'(a_en), 32'b0011);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("len.a.c4.busy", 32'(a_busy), 32'd0);
    chk("len.a.c4.en", 32'(a_en), 32'd0);

    // Reset pulsed mid-run clears outputs before the next edge; heartbeat restarts from zero.
    phase_len = LEN_DEF;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("mid.a.busy", 32'(a_busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_st("async.a", a_busy, a_done, a_to, a_cur, a_en, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    chk_st("async.b", b_busy, b_done, b_to, b_cur, b_en, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    chk("async.a.hb", 32'(a_hb), 32'd0);
    tick();
    reset = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      abort = (n == 5);
      chk($sformatf("hb.n%0d", n), 32'(a_hb), 32'((n / 4) % 2));
      chk($sformatf("post.busy.n%0d", n), 32'(a_busy), 32'd0);
    end
    abort = 1'b0;
    chk("post.a.en", 32'(a_en), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
